ram_responder: RTL and testbench
================================

RAM_RESPONDER -- requirements
Module: ram_responder

Interface
REQ-001 Parameter LAT, default 2, number of BUSY cycles before ACCESS (0 allowed).
REQ-002 Parameter DEPTH, default 1024, number of 32-bit words stored (power of two).
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 nRST  input  1  asynchronous, active-low reset.
REQ-005 ramREN  input  1  read request from memory controller.
REQ-006 ramWEN  input  1  write request from memory controller.
REQ-007 ramaddr  input  32  byte address, word-aligned.
REQ-008 ramstore  input  32  write data.
REQ-009 ramload  output  32  read data.
REQ-010 ramstate  output  2  ramstate_t from cpu_types_pkg: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

Function
REQ-011 Valid request SHALL be: exactly one of ramREN/ramWEN high, ramaddr[1:0]==0, and ramaddr < 4*DEPTH; word index = ramaddr[$clog2(DEPTH)+1:2].
REQ-012 Bad request SHALL be: ramREN and ramWEN both high, or either high with a misaligned or out-of-range address.
REQ-013 FSM states SHALL be IDLE, WAIT, DONE, FAULT; ramstate = FREE, BUSY, ACCESS, ERROR respectively.
REQ-014 IDLE: valid request -> capture addr and op, load counter with LAT, go to WAIT (DONE directly if LAT==0); bad request -> FAULT; else stay.
REQ-015 WAIT: counter SHALL decrement by 1 per cycle; at counter==1 the next state SHALL be DONE, so WAIT lasts exactly LAT cycles.
REQ-016 WAIT: if the request drops, the op changes, or ramaddr differs from the captured address, the block SHALL go to IDLE the next cycle (no memory effect); bad request -> FAULT.
REQ-017 DONE lasts exactly one cycle; ramload SHALL equal mem[captured word] combinationally during DONE for reads.
REQ-018 DONE write: mem[captured word] SHALL be updated with ramstore at the rising edge ending DONE, only if ramWEN is still high with the captured address.
REQ-019 After DONE: if a valid request is present with a different address or op, the next state SHALL be WAIT with the counter reloaded (DONE if LAT==0); otherwise IDLE.
REQ-020 The same request still held after DONE SHALL NOT re-trigger an access until it has been deasserted for at least one cycle.
REQ-021 FAULT SHALL hold while any request is asserted and return to IDLE the cycle after ramREN and ramWEN are both low; no memory effect in FAULT.
REQ-022 ramload SHALL be 0 in every state other than DONE-with-read.
REQ-023 Counter width SHALL be $clog2(LAT+1), minimum 1; it SHALL never wrap below 0.
REQ-024 Memory array SHALL NOT be cleared by reset; only control state is reset.

Reset
REQ-025 nRST low SHALL immediately force IDLE, counter 0, ramstate=FREE, ramload=0, captured address/op cleared.
REQ-026 nRST asserted during WAIT or DONE SHALL abort the access; no write SHALL commit.
REQ-027 The first edge after nRST deassertion SHALL evaluate requests as in IDLE.

Verification (LAT=2, DEPTH=1024)
REQ-028 Reset: nRST low, requests idle -> ramstate=FREE, ramload=0x00000000.
REQ-029 Write then read: WEN, addr 0x40, data 0xDEADBEEF -> BUSY,BUSY,ACCESS; drop WEN one cycle; REN addr 0x40 -> BUSY,BUSY,ACCESS with ramload=0xDEADBEEF.
REQ-030 Restart: REN 0x80, change to 0x84 in 2nd BUSY cycle -> FREE for one cycle, then BUSY,BUSY,ACCESS returning mem[0x84]; mem[0x80] is not read.
REQ-031 Faults: REN+WEN at 0x10 -> ERROR until both low, then FREE; REN at 0x41 -> ERROR; REN at 0x1000 -> ERROR; memory unchanged.
REQ-032 Abort: WEN 0x20 data 0x12345678, pulse nRST during 2nd BUSY -> FREE; later read of 0x20 returns prior contents.
REQ-033 Back-to-back: REN 0x00 then 0x04 immediately after ACCESS -> BUSY,BUSY,ACCESS,BUSY,BUSY,ACCESS with no FREE cycle between.

Source files
------------

// File: rtl/ram_responder_if.sv
// ram_responder_if: request/response bundle between a memory controller and
// the RAM responder model.
//   ramREN   : read request            (controller -> RAM)
//   ramWEN   : write request           (controller -> RAM)
//   ramaddr  : 32-bit byte address     (controller -> RAM)
//   ramstore : 32-bit write data       (controller -> RAM)
//   ramload  : 32-bit read data        (RAM -> controller)
//   ramstate : FREE=0 BUSY=1 ACCESS=2 ERROR=3 (RAM -> controller)
interface ram_responder_if;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_responder.sv
// ram_responder: word-addressed RAM that answers single requests with a
// programmable number of BUSY cycles followed by one ACCESS cycle.
//   CLK  : clock, all state changes on the rising edge
//   nRST : asynchronous active-low reset (control state only, not memory)
//   bus  : ram_responder_if.slave (ramREN/ramWEN/ramaddr/ramstore in,
//          ramload/ramstate out)
//   LAT  : BUSY cycles before ACCESS (0 allowed)
//   DEPTH: number of 32-bit words (power of two)
module ram_responder #(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 1024
) (
  input logic            CLK,
  input logic            nRST,
  ram_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LAT == 0) ? 1 : $clog2(LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [1:0]    S_START = (LAT == 0) ? S_DONE : S_WAIT;
  localparam logic [CW-1:0] CNT_LD  = CW'(LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          op_q, op_d;        // 1 = write
  logic          block_q, block_d;  // completed request still being held

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] word_q;
  logic          mem_we;

  logic req_any, addr_ok, valid, bad, same;

  assign word_q = addr_q[AW+1:2];

  always_comb begin
    req_any = bus.ramREN | bus.ramWEN;
    addr_ok = (bus.ramaddr[1:0] == 2'b00) && (bus.ramaddr[31:AW+2] == '0);
    valid   = (bus.ramREN ^ bus.ramWEN) && addr_ok;
    bad     = (bus.ramREN & bus.ramWEN) | (req_any & ~addr_ok);
    same    = valid && (bus.ramWEN == op_q) && (bus.ramaddr == addr_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    block_d = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // A request that already completed and is still held is ignored
        // until it drops or changes.
        if (bad) begin
          state_d = S_FAULT;
        end else if (valid && !(block_q && same)) begin
          state_d = S_START;
          cnt_d   = CNT_LD;
          addr_d  = bus.ramaddr;
          op_d    = bus.ramWEN;
        end else begin
          block_d = block_q && same;
        end
      end
      S_WAIT: begin
        if (bad) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else if (!same) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        mem_we = op_q && bus.ramWEN && (bus.ramaddr == addr_q);
        if (valid && !same) begin
          state_d = S_START;
          cnt_d   = CNT_LD;
          addr_d  = bus.ramaddr;
          op_d    = bus.ramWEN;
        end else begin
          state_d = S_IDLE;
          block_d = same;
        end
      end
      S_FAULT: begin
        if (!req_any) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= 1'b0;
      block_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      block_q <= block_d;
    end
  end

  // Storage is deliberately outside the reset domain; an aborted access
  // cannot write because reset already forced the FSM out of DONE.
  always_ff @(posedge CLK) begin
    if (mem_we) mem[word_q] <= bus.ramstore;
  end

  assign bus.ramstate = state_q;
  assign bus.ramload  = (state_q == S_DONE && !op_q) ? mem[word_q] : '0;

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  ram_responder_if bus ();

  ram_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  st;
    logic [31:0] ld;
    string       tag;
  } vec_t;

  typedef struct {
    logic [1:0]  st;
    logic [31:0] ld;
    string       tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  function automatic void add(input logic ren, input logic wen,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] st, input logic [31:0] ld,
                              input string tag);
    vec_t v;
    v.ren = ren; v.wen = wen; v.addr = a; v.data = d;
    v.st = st; v.ld = ld; v.tag = tag;
    vecs.push_back(v);
  endfunction

  function automatic void add_write(input logic [31:0] a, input logic [31:0] d, input string tag);
    add(1'b0, 1'b1, a, d, FREE,   '0, {tag, "_req"});
    add(1'b0, 1'b1, a, d, BUSY,   '0, {tag, "_busy1"});
    add(1'b0, 1'b1, a, d, BUSY,   '0, {tag, "_busy2"});
    add(1'b0, 1'b1, a, d, ACCESS, '0, {tag, "_access"});
    add(1'b0, 1'b0, a, '0, FREE,  '0, {tag, "_idle"});
  endfunction

  function automatic void add_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    add(1'b1, 1'b0, a, '0, FREE,   '0,  {tag, "_req"});
    add(1'b1, 1'b0, a, '0, BUSY,   '0,  {tag, "_busy1"});
    add(1'b1, 1'b0, a, '0, BUSY,   '0,  {tag, "_busy2"});
    add(1'b1, 1'b0, a, '0, ACCESS, exp, {tag, "_access"});
    add(1'b0, 1'b0, a, '0, FREE,   '0,  {tag, "_idle"});
  endfunction

  task automatic drive(input logic ren, input logic wen,
                       input logic [31:0] a, input logic [31:0] d);
    bus.ramREN   = ren;
    bus.ramWEN   = wen;
    bus.ramaddr  = a;
    bus.ramstore = d;
  endtask

  task automatic expect_now(input logic [1:0] st, input logic [31:0] ld, input string tag);
    exp_t e;
    e.st = st; e.ld = ld; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty got nothing to compare");
      return;
    end
    e = sb.pop_front();
    if (bus.ramstate === e.st) n_pass++;
    else $display("FAIL %s ramstate got %0d want %0d", e.tag, bus.ramstate, e.st);
    n_chk++;
    if (bus.ramload === e.ld) n_pass++;
    else $display("FAIL %s ramload got %h want %h", e.tag, bus.ramload, e.ld);
  endtask

  // One cycle: inputs applied just after the edge, outputs sampled mid-cycle.
  task automatic run(input logic ren, input logic wen,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] st, input logic [31:0] ld, input string tag);
    @(posedge CLK);
    #1;
    drive(ren, wen, a, d);
    expect_now(st, ld, tag);
    @(negedge CLK);
    check_out();
  endtask

  task automatic run_table();
    for (int i = 0; i < vecs.size(); i++)
      run(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].data,
          vecs[i].st, vecs[i].ld, vecs[i].tag);
    vecs.delete();
  endtask

  // Reset pulse placed inside the cycle that currently shows cur_st.
  task automatic reset_pulse_in(input logic [1:0] cur_st, input string tag);
    @(posedge CLK);
    #1;
    expect_now(cur_st, '0, {tag, "_before"});
    check_out();
    #1 nRST = 1'b0;
    #1;
    expect_now(FREE, '0, {tag, "_in_reset"});
    check_out();
    #1 nRST = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    expect_now(FREE, '0, {tag, "_after"});
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive(1'b0, 1'b0, '0, '0);
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    expect_now(FREE, '0, "reset_idle");
    check_out();
    drive(1'b1, 1'b0, 32'h40, '0);
    @(negedge CLK);
    expect_now(FREE, '0, "reset_with_req");
    check_out();
    drive(1'b0, 1'b0, '0, '0);
    #2 nRST = 1'b1;

    add_write(32'h40, 32'hDEADBEEF, "wr40");
    add_read (32'h40, 32'hDEADBEEF, "rd40");
    add_write(32'h00, 32'h00000A00, "wr00");
    add_write(32'h04, 32'h00000A04, "wr04");
    add_write(32'h80, 32'hAAAA0080, "wr80");
    add_write(32'h84, 32'h55550084, "wr84");
    add_write(32'h20, 32'hCAFE0020, "wr20");

    // address change during second BUSY restarts on the new address
    add(1'b1, 1'b0, 32'h80, '0, FREE,   '0,           "rst_req80");
    add(1'b1, 1'b0, 32'h80, '0, BUSY,   '0,           "rst_busy1");
    add(1'b1, 1'b0, 32'h84, '0, BUSY,   '0,           "rst_busy2_chg");
    add(1'b1, 1'b0, 32'h84, '0, FREE,   '0,           "rst_free");
    add(1'b1, 1'b0, 32'h84, '0, BUSY,   '0,           "rst_busy1b");
    add(1'b1, 1'b0, 32'h84, '0, BUSY,   '0,           "rst_busy2b");
    add(1'b1, 1'b0, 32'h84, '0, ACCESS, 32'h55550084, "rst_access84");
    add(1'b0, 1'b0, 32'h0,  '0, FREE,   '0,           "rst_idle");

    // op change during BUSY aborts with no write
    add(1'b1, 1'b0, 32'h80, '0,           FREE, '0, "opchg_req");
    add(1'b1, 1'b0, 32'h80, '0,           BUSY, '0, "opchg_busy1");
    add(1'b0, 1'b1, 32'h80, 32'h0BADBAD0, BUSY, '0, "opchg_to_wr");
    add(1'b0, 1'b0, 32'h80, '0,           FREE, '0, "opchg_free");
    add_read(32'h80, 32'hAAAA0080, "rd80");

    // faults
    add(1'b1, 1'b1, 32'h10, '0, FREE,  '0, "both_req");
    add(1'b1, 1'b1, 32'h10, '0, ERROR, '0, "both_err");
    add(1'b1, 1'b0, 32'h10, '0, ERROR, '0, "both_hold_one");
    add(1'b0, 1'b0, 32'h10, '0, ERROR, '0, "both_released");
    add(1'b0, 1'b0, 32'h10, '0, FREE,  '0, "both_free");
    add(1'b1, 1'b0, 32'h41, '0, FREE,  '0, "mis_req");
    add(1'b0, 1'b0, 32'h0,  '0, ERROR, '0, "mis_err");
    add(1'b0, 1'b0, 32'h0,  '0, FREE,  '0, "mis_free");
    add(1'b1, 1'b0, 32'h1000, '0, FREE,  '0, "oor_rd_req");
    add(1'b0, 1'b0, 32'h0,    '0, ERROR, '0, "oor_rd_err");
    add(1'b0, 1'b0, 32'h0,    '0, FREE,  '0, "oor_rd_free");
    add(1'b0, 1'b1, 32'h1000, 32'hBAD00000, FREE,  '0, "oor_wr_req");
    add(1'b0, 1'b1, 32'h1000, 32'hBAD00000, ERROR, '0, "oor_wr_err");
    add(1'b0, 1'b0, 32'h0,    '0,           ERROR, '0, "oor_wr_rel");
    add(1'b0, 1'b0, 32'h0,    '0,           FREE,  '0, "oor_wr_free");
    add(1'b0, 1'b1, 32'h42, 32'hBAD00042, FREE,  '0, "mis_wr_req");
    add(1'b0, 1'b0, 32'h0,  '0,           ERROR, '0, "mis_wr_err");
    add(1'b0, 1'b0, 32'h0,  '0,           FREE,  '0, "mis_wr_free");
    add_read(32'h00, 32'h00000A00, "rd00_after_fault");
    add_read(32'h40, 32'hDEADBEEF, "rd40_after_fault");

    // held request does not re-trigger
    add(1'b1, 1'b0, 32'h40, '0, FREE,   '0,           "hold_req");
    add(1'b1, 1'b0, 32'h40, '0, BUSY,   '0,           "hold_busy1");
    add(1'b1, 1'b0, 32'h40, '0, BUSY,   '0,           "hold_busy2");
    add(1'b1, 1'b0, 32'h40, '0, ACCESS, 32'hDEADBEEF, "hold_access");
    add(1'b1, 1'b0, 32'h40, '0, FREE,   '0,           "hold_still1");
    add(1'b1, 1'b0, 32'h40, '0, FREE,   '0,           "hold_still2");
    add(1'b0, 1'b0, 32'h0,  '0, FREE,   '0,           "hold_drop");

    // write dropped during ACCESS does not commit
    add(1'b0, 1'b1, 32'h40, 32'h11111111, FREE,   '0, "wdrop_req");
    add(1'b0, 1'b1, 32'h40, 32'h11111111, BUSY,   '0, "wdrop_busy1");
    add(1'b0, 1'b1, 32'h40, 32'h11111111, BUSY,   '0, "wdrop_busy2");
    add(1'b0, 1'b0, 32'h40, 32'h11111111, ACCESS, '0, "wdrop_access");
    add(1'b0, 1'b0, 32'h0,  '0,           FREE,   '0, "wdrop_idle");
    add_read(32'h40, 32'hDEADBEEF, "rd40_after_wdrop");

    // back-to-back reads with no FREE gap
    add(1'b1, 1'b0, 32'h00, '0, FREE,   '0,           "b2b_req0");
    add(1'b1, 1'b0, 32'h00, '0, BUSY,   '0,           "b2b_busy1a");
    add(1'b1, 1'b0, 32'h00, '0, BUSY,   '0,           "b2b_busy2a");
    add(1'b1, 1'b0, 32'h04, '0, ACCESS, 32'h00000A00, "b2b_access0");
    add(1'b1, 1'b0, 32'h04, '0, BUSY,   '0,           "b2b_busy1b");
    add(1'b1, 1'b0, 32'h04, '0, BUSY,   '0,           "b2b_busy2b");
    add(1'b1, 1'b0, 32'h04, '0, ACCESS, 32'h00000A04, "b2b_access4");
    add(1'b0, 1'b0, 32'h0,  '0, FREE,   '0,           "b2b_idle");

    run_table();

    // reset during second BUSY of a write
    run(1'b0, 1'b1, 32'h20, 32'h12345678, FREE, '0, "abort_busy_req");
    run(1'b0, 1'b1, 32'h20, 32'h12345678, BUSY, '0, "abort_busy_b1");
    reset_pulse_in(BUSY, "abort_busy2");

    // reset during ACCESS of a write
    run(1'b0, 1'b1, 32'h20, 32'h12345678, FREE, '0, "abort_acc_req");
    run(1'b0, 1'b1, 32'h20, 32'h12345678, BUSY, '0, "abort_acc_b1");
    run(1'b0, 1'b1, 32'h20, 32'h12345678, BUSY, '0, "abort_acc_b2");
    reset_pulse_in(ACCESS, "abort_access");

    add_read(32'h20, 32'hCAFE0020, "rd20_after_abort");
    run_table();

    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
